// File: rtl/axi_pkg.sv
// Shared types and encodings for the AXI4 memory responder.
package axi_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, BRESP} t_slv_state;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_slave_ram.sv
// Single-port word RAM, byte-enable write, registered read (1 cycle).
// No backpressure: a read updates rdat only when en=1 and no byte is being written.
module axi_slave_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   idx,
  input  logic [DATA_W-1:0]   wdat,
  output logic [DATA_W-1:0]   rdat
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
    end
  end

  // Only the read register is reset so R_DATA reads zero out of reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                 rdat <= '0;
    else if (en && we == '0)  rdat <= mem[idx];
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 responder over an internal RAM, one burst at a time; AXI_SLAVE_RANGE_CHECK_EN adds out-of-range SLVERR.
// Latency: first R beat the cycle after AR; B the cycle after the last W beat.
// Backpressure: R/B held stable until READY; AR/AW only accepted in IDLE, read wins ties.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        AW_VALID,
  output logic                        AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic [7:0]                  AW_LEN,
  input  logic [2:0]                  AW_SIZE,
  input  logic [1:0]                  AW_BURST,
  input  logic [2:0]                  AW_PROT,
  input  logic                        W_VALID,
  output logic                        W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  input  logic                        W_LAST,
  output logic                        B_VALID,
  input  logic                        B_READY,
  output logic [1:0]                  B_RESP,
  input  logic                        AR_VALID,
  output logic                        AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
  input  logic [7:0]                  AR_LEN,
  input  logic [2:0]                  AR_SIZE,
  input  logic [1:0]                  AR_BURST,
  input  logic [2:0]                  AR_PROT,
  output logic                        R_VALID,
  input  logic                        R_READY,
  output logic [AXI_DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]                  R_RESP,
  output logic                        R_LAST
);

  t_slv_state                  state;
  logic [AXI_ADDR_WIDTH-1:0]   addr, next_addr, rd_addr;
  logic [7:0]                  len, cnt;
  logic [1:0]                  burst;
  logic                        idle_rdy, wr_err, rd_oor, rd_oor_nxt, wr_oor;
  logic                        ar_hs, aw_hs, r_hs, w_hs, b_hs, w_final, w_err_beat;
  logic                        ram_en;
  logic [AXI_DATA_WIDTH/8-1:0] ram_we;
  logic [MEM_ADDR_WIDTH-1:0]   ram_idx;
  logic [AXI_DATA_WIDTH-1:0]   ram_q;
  logic                        unused_ok;

  assign AR_READY  = idle_rdy;
  assign AW_READY  = idle_rdy & ~AR_VALID;
  assign ar_hs     = AR_VALID & AR_READY;
  assign aw_hs     = AW_VALID & AW_READY;
  assign r_hs      = R_VALID & R_READY;
  assign w_hs      = W_VALID & W_READY;
  assign b_hs      = B_VALID & B_READY;
  assign w_final   = (cnt == len);
  // WRAP and the reserved encoding both step like INCR.
  assign next_addr = (burst == BURST_FIXED) ? addr : addr + AXI_ADDR_WIDTH'(4);

  // Prefetch the next word on each R handshake so beats stream without bubbles.
  assign rd_addr = (state == IDLE) ? AR_ADDR : (r_hs ? next_addr : addr);
  assign ram_idx = (state == WR) ? addr[MEM_ADDR_WIDTH+1:2] : rd_addr[MEM_ADDR_WIDTH+1:2];
  assign ram_en  = ar_hs | r_hs;
  assign ram_we  = (w_hs && !wr_oor) ? W_STRB : '0;

`ifdef AXI_SLAVE_RANGE_CHECK_EN
  assign rd_oor_nxt = |rd_addr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
  assign wr_oor     = |addr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
`else
  assign rd_oor_nxt = 1'b0;
  assign wr_oor     = 1'b0;
`endif

  assign w_err_beat = (W_LAST != w_final) | wr_oor;
  assign R_DATA     = rd_oor ? '0 : ram_q;
  assign R_RESP     = rd_oor ? RESP_SLVERR : RESP_OKAY;
  assign unused_ok  = ^{AW_SIZE, AW_PROT, AR_SIZE, AR_PROT, rd_addr, addr};

  axi_slave_ram #(.ADDR_W(MEM_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH)) u_ram (
    .clk  (clk),
    .arst (arst),
    .en   (ram_en),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdat (W_DATA),
    .rdat (ram_q)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      idle_rdy <= 1'b0;
      addr     <= '0;
      len      <= '0;
      cnt      <= '0;
      burst    <= BURST_INCR;
      wr_err   <= 1'b0;
      rd_oor   <= 1'b0;
      W_READY  <= 1'b0;
      B_VALID  <= 1'b0;
      B_RESP   <= RESP_OKAY;
      R_VALID  <= 1'b0;
      R_LAST   <= 1'b0;
    end else begin
      if (ram_en) rd_oor <= rd_oor_nxt;
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (ar_hs) begin
            addr     <= AR_ADDR;
            len      <= AR_LEN;
            burst    <= AR_BURST;
            cnt      <= '0;
            idle_rdy <= 1'b0;
            R_VALID  <= 1'b1;
            R_LAST   <= (AR_LEN == 8'd0);
            state    <= RD;
          end else if (aw_hs) begin
            addr     <= AW_ADDR;
            len      <= AW_LEN;
            burst    <= AW_BURST;
            cnt      <= '0;
            wr_err   <= 1'b0;
            idle_rdy <= 1'b0;
            W_READY  <= 1'b1;
            state    <= WR;
          end
        end
        RD: begin
          if (r_hs) begin
            if (R_LAST) begin
              R_VALID  <= 1'b0;
              R_LAST   <= 1'b0;
              idle_rdy <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt    <= cnt + 8'd1;
              addr   <= next_addr;
              R_LAST <= (cnt + 8'd1 == len);
            end
          end
        end
        WR: begin
          if (w_hs) begin
            cnt    <= cnt + 8'd1;
            addr   <= next_addr;
            wr_err <= wr_err | w_err_beat;
            // Burst length comes from AW_LEN alone; W_LAST only feeds the error flag.
            if (w_final) begin
              W_READY <= 1'b0;
              B_VALID <= 1'b1;
              B_RESP  <= (wr_err | w_err_beat) ? RESP_SLVERR : RESP_OKAY;
              state   <= BRESP;
            end
          end
        end
        BRESP: begin
          if (b_hs) begin
            B_VALID  <= 1'b0;
            B_RESP   <= RESP_OKAY;
            idle_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        arst;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, W_LAST, B_VALID, B_READY;
  logic [63:0] AW_ADDR, AR_ADDR;
  logic [7:0]  AW_LEN, AR_LEN;
  logic [2:0]  AW_SIZE, AW_PROT, AR_SIZE, AR_PROT;
  logic [1:0]  AW_BURST, AR_BURST, B_RESP, R_RESP;
  logic [31:0] W_DATA, R_DATA;
  logic [3:0]  W_STRB;
  logic        AR_VALID, AR_READY, R_VALID, R_READY, R_LAST;

  int checks = 0;
  int errors = 0;

  logic [31:0] wdata [256];
  logic [3:0]  wstrb [256];
  logic [31:0] rdat  [256];
  logic [1:0]  rresp [256];
  logic [1:0]  bresp;
  int          last_cnt, last_idx, hold_viol, first_wait, b_drop;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .arst(arst),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_LEN(AW_LEN),
    .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST), .AW_PROT(AW_PROT),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_LEN(AR_LEN),
    .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST), .AR_PROT(AR_PROT),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST)
  );

  task automatic do_write(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                          input int last_at, input int b_delay);
    int cyc;
    AW_ADDR = a; AW_LEN = l; AW_BURST = b; AW_VALID = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!AW_READY && cyc < 50) begin @(negedge clk); cyc++; end
    if (!AW_READY) begin
      checks++; errors++; $display("FAIL aw_timeout: AW_READY=%b required 1", AW_READY);
      AW_VALID = 1'b0; return;
    end
    @(posedge clk); #1 AW_VALID = 1'b0;
    W_VALID = 1'b1;
    for (int i = 0; i <= int'(l); i++) begin
      W_DATA = wdata[i]; W_STRB = wstrb[i]; W_LAST = (i == last_at);
      cyc = 0;
      @(negedge clk);
      while (!W_READY && cyc < 50) begin @(negedge clk); cyc++; end
      if (!W_READY) begin
        checks++; errors++; $display("FAIL w_timeout: beat %0d W_READY=%b required 1", i, W_READY);
        W_VALID = 1'b0; W_LAST = 1'b0; return;
      end
      @(posedge clk); #1;
    end
    W_VALID = 1'b0; W_LAST = 1'b0;
    b_drop = 0;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk); if (!B_VALID) b_drop++;
      @(posedge clk); #1;
    end
    B_READY = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!B_VALID && cyc < 50) begin @(negedge clk); cyc++; end
    if (!B_VALID) begin
      checks++; errors++; $display("FAIL b_timeout: B_VALID=%b required 1", B_VALID);
    end
    bresp = B_RESP;
    @(posedge clk); #1 B_READY = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b, input bit toggle);
    int cyc, n;
    bit held;
    logic [31:0] hd;
    logic hl;
    last_cnt = 0; last_idx = -1; hold_viol = 0; first_wait = 0;
    held = 0; hd = '0; hl = 1'b0; n = 0;
    AR_ADDR = a; AR_LEN = l; AR_BURST = b; AR_VALID = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!AR_READY && cyc < 50) begin @(negedge clk); cyc++; end
    if (!AR_READY) begin
      checks++; errors++; $display("FAIL ar_timeout: AR_READY=%b required 1", AR_READY);
      AR_VALID = 1'b0; return;
    end
    @(posedge clk); #1 AR_VALID = 1'b0;
    R_READY = !toggle;
    cyc = 0;
    while (n <= int'(l) && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (n == 0 && !R_VALID) first_wait++;
      if (held && (!R_VALID || R_DATA !== hd || R_LAST !== hl)) hold_viol++;
      held = 0;
      if (R_VALID) begin
        if (R_READY) begin
          rdat[n] = R_DATA; rresp[n] = R_RESP;
          if (R_LAST) begin last_cnt++; last_idx = n; end
          n++;
        end else begin
          held = 1; hd = R_DATA; hl = R_LAST;
        end
      end
      @(posedge clk); #1;
      if (toggle) R_READY = !R_READY;
    end
    R_READY = 1'b0;
    if (n <= int'(l)) begin
      checks++; errors++; $display("FAIL r_timeout: got %0d beats required %0d", n, int'(l) + 1);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({AW_READY, W_READY, B_VALID, AR_READY, R_VALID, R_LAST} !== 6'b0 || B_RESP !== 2'b00 ||
        R_DATA !== 32'h0 || R_RESP !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: awr=%b wr=%b bv=%b br=%b arr=%b rv=%b rd=%h rr=%b rl=%b required all 0",
               AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP, R_LAST);
    end
    arst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (AR_READY !== 1'b1 || AW_READY !== 1'b1) begin
      errors++; $display("FAIL idle_ready: AR_READY=%b AW_READY=%b required 1 1", AR_READY, AW_READY);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    wdata[0] = 32'hCAFE0000; wstrb[0] = 4'hF;
    do_write(64'h0, 8'd0, 2'b01, 0, 0);
    wdata[0] = 32'hDEADBEEF;
    do_write(64'h10, 8'd0, 2'b01, 0, 0);
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b required 00", bresp); end
    do_read(64'h10, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 32'hDEADBEEF || rresp[0] !== 2'b00) begin
      errors++; $display("FAIL single_rdata: got %h/%b required deadbeef/00", rdat[0], rresp[0]);
    end
    checks++;
    if (last_cnt !== 1 || last_idx !== 0) begin
      errors++; $display("FAIL single_rlast: count %0d at %0d required 1 at 0", last_cnt, last_idx);
    end
    checks++;
    if (first_wait !== 0) begin
      errors++; $display("FAIL read_latency: %0d idle cycles before R_VALID required 0", first_wait);
    end
    @(negedge clk);
    checks++;
    if (R_VALID !== 1'b0) begin errors++; $display("FAIL rvalid_drop: got %b required 0", R_VALID); end
    @(posedge clk); #1;
  endtask

  task automatic test_incr16();
    for (int i = 0; i < 16; i++) begin wdata[i] = i * 32'h01010101; wstrb[i] = 4'hF; end
    do_write(64'h100, 8'd15, 2'b01, 15, 0);
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", bresp); end
    do_read(64'h100, 8'd15, 2'b01, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rdat[i] !== i * 32'h01010101) begin
        errors++; $display("FAIL incr_beat%0d: got %h required %h", i, rdat[i], i * 32'h01010101);
      end
    end
    checks++;
    if (last_cnt !== 1 || last_idx !== 15) begin
      errors++; $display("FAIL incr_rlast: count %0d at %0d required 1 at 15", last_cnt, last_idx);
    end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL incr_hold: %0d changes while stalled required 0", hold_viol); end
  endtask

  task automatic test_strobe();
    wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'hF;
    do_write(64'h20, 8'd0, 2'b01, 0, 0);
    wdata[0] = 32'h00000000; wstrb[0] = 4'b0101;
    do_write(64'h20, 8'd0, 2'b01, 0, 0);
    do_read(64'h20, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 32'hFF00FF00) begin errors++; $display("FAIL strobe: got %h required ff00ff00", rdat[0]); end
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 3; i++) begin wdata[i] = 32'(i + 1); wstrb[i] = 4'hF; end
    do_write(64'h40, 8'd2, 2'b00, 2, 0);
    do_read(64'h40, 8'd2, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdat[i] !== 32'h3) begin errors++; $display("FAIL fixed_beat%0d: got %h required 00000003", i, rdat[i]); end
    end
    checks++;
    if (last_idx !== 2) begin errors++; $display("FAIL fixed_rlast: at %0d required 2", last_idx); end
  endtask

  task automatic test_priority();
    int viol, n, cyc;
    AR_ADDR = 64'h10; AR_LEN = 8'd1; AR_BURST = 2'b01;
    AW_ADDR = 64'h30; AW_LEN = 8'd0; AW_BURST = 2'b01;
    AR_VALID = 1'b1; AW_VALID = 1'b1;
    @(negedge clk);
    checks++;
    if (AR_READY !== 1'b1 || AW_READY !== 1'b0) begin
      errors++; $display("FAIL prio_idle: AR_READY=%b AW_READY=%b required 1 0", AR_READY, AW_READY);
    end
    @(posedge clk); #1 AR_VALID = 1'b0; R_READY = 1'b1;
    viol = 0; n = 0; cyc = 0;
    while (n < 2 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (AW_READY) viol++;
      if (R_VALID) n++;
      @(posedge clk); #1;
    end
    R_READY = 1'b0;
    checks++;
    if (viol !== 0 || n !== 2) begin
      errors++; $display("FAIL prio_during_read: aw_ready seen %0d beats %0d required 0 2", viol, n);
    end
    @(negedge clk);
    checks++;
    if (AW_READY !== 1'b1) begin errors++; $display("FAIL prio_aw_after: AW_READY=%b required 1", AW_READY); end
    @(posedge clk); #1 AW_VALID = 1'b0;
    W_VALID = 1'b1; W_DATA = 32'h12345678; W_STRB = 4'hF; W_LAST = 1'b1;
    @(negedge clk);
    checks++;
    if (W_READY !== 1'b1) begin errors++; $display("FAIL prio_wready: got %b required 1", W_READY); end
    @(posedge clk); #1 W_VALID = 1'b0; W_LAST = 1'b0; B_READY = 1'b1;
    @(negedge clk);
    checks++;
    if (B_VALID !== 1'b1 || B_RESP !== 2'b00) begin
      errors++; $display("FAIL prio_b: B_VALID=%b B_RESP=%b required 1 00", B_VALID, B_RESP);
    end
    @(posedge clk); #1 B_READY = 1'b0;
    do_read(64'h30, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 32'h12345678) begin errors++; $display("FAIL prio_readback: got %h required 12345678", rdat[0]); end
  endtask

  task automatic test_wlast_err();
    for (int i = 0; i < 4; i++) begin wdata[i] = 32'hA0 + 32'(i); wstrb[i] = 4'hF; end
    do_write(64'h200, 8'd3, 2'b01, 1, 5);
    checks++;
    if (bresp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp: got %b required 10", bresp); end
    checks++;
    if (b_drop !== 0) begin errors++; $display("FAIL bvalid_hold: dropped %0d cycles required 0", b_drop); end
    do_read(64'h200, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdat[i] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL early_wlast_data%0d: got %h required %h", i, rdat[i], 32'hA0 + 32'(i));
      end
    end
    wdata[0] = 32'h55; wstrb[0] = 4'hF;
    do_write(64'h210, 8'd0, 2'b01, 0, 0);
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL err_cleared: got %b required 00", bresp); end
    wdata[1] = 32'h66; wstrb[1] = 4'hF;
    do_write(64'h214, 8'd1, 2'b01, -1, 0);
    checks++;
    if (bresp !== 2'b10) begin errors++; $display("FAIL missing_wlast: got %b required 10", bresp); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    AR_ADDR = 64'h100; AR_LEN = 8'd7; AR_BURST = 2'b01; AR_VALID = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!AR_READY && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk); #1 AR_VALID = 1'b0; R_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (R_VALID !== 1'b1 || R_DATA !== 32'h03030303) begin
      errors++; $display("FAIL pre_reset_beat3: R_VALID=%b R_DATA=%h required 1 03030303", R_VALID, R_DATA);
    end
    #1 arst = 1'b1;
    #1;
    checks++;
    if ({AW_READY, W_READY, B_VALID, AR_READY, R_VALID, R_LAST} !== 6'b0 || R_DATA !== 32'h0 ||
        R_RESP !== 2'b00 || B_RESP !== 2'b00) begin
      errors++; $display("FAIL mid_reset_outputs: arr=%b rv=%b rd=%h rl=%b required all 0",
                         AR_READY, R_VALID, R_DATA, R_LAST);
    end
    R_READY = 1'b0;
    @(negedge clk) arst = 1'b0;
    do_read(64'h10, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL post_reset_read: got %h required deadbeef", rdat[0]); end
  endtask

  task automatic test_range();
    do_read(64'h1000, 8'd0, 2'b01, 1'b0);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
    checks++;
    if (rdat[0] !== 32'h0 || rresp[0] !== 2'b10) begin
      errors++; $display("FAIL range_read: got %h/%b required 00000000/10", rdat[0], rresp[0]);
    end
    wdata[0] = 32'h99; wstrb[0] = 4'hF;
    do_write(64'h1000, 8'd0, 2'b01, 0, 0);
    checks++;
    if (bresp !== 2'b10) begin errors++; $display("FAIL range_write_bresp: got %b required 10", bresp); end
    do_read(64'h0, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rdat[0] !== 32'hCAFE0000) begin errors++; $display("FAIL range_write_dropped: got %h required cafe0000", rdat[0]); end
`else
    checks++;
    if (rdat[0] !== 32'hCAFE0000 || rresp[0] !== 2'b00) begin
      errors++; $display("FAIL alias_read: got %h/%b required cafe0000/00", rdat[0], rresp[0]);
    end
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arst = 1'b1;
    AW_VALID = 0; AW_ADDR = '0; AW_LEN = '0; AW_SIZE = 3'b010; AW_BURST = 2'b01; AW_PROT = '0;
    W_VALID = 0; W_DATA = '0; W_STRB = '0; W_LAST = 0; B_READY = 0;
    AR_VALID = 0; AR_ADDR = '0; AR_LEN = '0; AR_SIZE = 3'b010; AR_BURST = 2'b01; AR_PROT = '0;
    R_READY = 0;
    test_reset();
    test_single();
    test_incr16();
    test_strobe();
    test_fixed();
    test_priority();
    test_wlast_err();
    test_mid_reset();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI4 subordinate (responder) backed by an internal word-addressed RAM; the memory-side endpoint for the core's AXI read/write burst master.
- Used as the simulation/FPGA stand-in for external memory.
- Services one transaction at a time: an AR→R burst, or an AW→W→B burst, with byte-strobed writes.

Parameters:
- AXI_ADDR_WIDTH, 64, address width of AR_ADDR/AW_ADDR.
- AXI_DATA_WIDTH, 32, data beat width; only 32 is supported.
- MEM_ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).

Ports:
- clk  in  1  clock, all logic on rising edge.
- arst  in  1  asynchronous, active-high reset.
- AW_VALID  in  1  write address valid.
- AW_READY  out  1  write address accepted.
- AW_ADDR  in  AXI_ADDR_WIDTH  write start byte address.
- AW_LEN  in  8  write beats minus one.
- AW_SIZE  in  3  beat size; ignored, 4 bytes implied.
- AW_BURST  in  2  burst type.
- AW_PROT  in  3  ignored.
- W_VALID  in  1  write data valid.
- W_READY  out  1  write data accepted.
- W_DATA  in  AXI_DATA_WIDTH  write beat.
- W_STRB  in  AXI_DATA_WIDTH/8  byte enables.
- W_LAST  in  1  final write beat marker.
- B_VALID  out  1  write response valid.
- B_READY  in  1  write response accepted.
- B_RESP  out  2  write response code.
- AR_VALID  in  1  read address valid.
- AR_READY  out  1  read address accepted.
- AR_ADDR  in  AXI_ADDR_WIDTH  read start byte address.
- AR_LEN  in  8  read beats minus one.
- AR_SIZE  in  3  ignored, 4 bytes implied.
- AR_BURST  in  2  burst type.
- AR_PROT  in  3  ignored.
- R_VALID  out  1  read data valid.
- R_READY  in  1  read data accepted.
- R_DATA  out  AXI_DATA_WIDTH  read beat.
- R_RESP  out  2  read response code.
- R_LAST  out  1  final read beat marker.

Behaviour:
- Reset: asynchronous on arst high. State = IDLE. Reset values: AW_READY=0, W_READY=0, B_VALID=0, B_RESP=00, AR_READY=0, R_VALID=0, R_DATA=0, R_RESP=00, R_LAST=0. RAM contents are not reset. Reset mid-burst abandons the transaction.
- States: IDLE, RD (R beats), WR (W beats), BRESP.
- IDLE:
  - AR_READY=1.
  - AW_READY=1 only when AR_VALID=0, so a read wins when AR_VALID and AW_VALID are simultaneous.
  - On AR handshake: latch addr, len, burst; beat count=0; go RD.
  - On AW handshake: latch the same fields; go WR.
- Burst length and addressing:
  - Beats = LEN+1 (1..256).
  - Word index = addr[MEM_ADDR_WIDTH+1:2]; byte offset bits [1:0] ignored.
  - INCR (01) and WRAP (10): addr += 4 after each handshaken beat.
  - FIXED (00): addr held. Reserved (11): treated as INCR.
  - Index wraps modulo RAM depth.
- RD:
  - R_VALID=1 starting the cycle after the AR handshake.
  - R_DATA = RAM[current index] (registered read; the next word is prefetched on each handshake, so there is no bubble between beats).
  - R_LAST=1 when count==LEN. R_RESP=00.
  - R_READY=0: R_DATA, R_LAST and R_VALID are held stable.
  - Handshake with R_LAST: return to IDLE; R_VALID drops the next cycle.
- WR:
  - W_READY=1.
  - On each W handshake, write the bytes where W_STRB[i]=1; count++.
  - The burst ends on the handshake where count==LEN, independent of W_LAST; go BRESP.
  - W_LAST protocol error, latched for this burst: W_LAST=1 when count!=LEN, or W_LAST=0 on the final beat. The offending data is still written.
- BRESP:
  - B_VALID=1 and held until B_READY.
  - B_RESP=10 (SLVERR) if the W_LAST protocol error was latched, else 00.
  - On handshake: go IDLE.
- No outstanding-transaction overlap: AR_READY/AW_READY are 0 outside IDLE.
- Minimum transaction time: read = 1 + beats cycles; write = 1 + beats + 1 cycles.

Optional Feature:
- Macro: AXI_SLAVE_RANGE_CHECK_EN.
- Defined: any beat whose byte address is at or above 4·2^MEM_ADDR_WIDTH is out of range.
  - Read: returns R_DATA=0 with R_RESP=10 for that beat.
  - Write: the beat is dropped (no RAM update) and B_RESP=10.
  - The burst still completes normally.
- Undefined: upper address bits are ignored; accesses alias modulo RAM size; responses are always 00 unless the W_LAST protocol error occurs.

Decomposition:
- Package axi_pkg:
  - state enum t_slv_state {IDLE, RD, WR, BRESP}.
  - Burst constants BURST_FIXED=00, BURST_INCR=01, BURST_WRAP=10.
  - Response constants RESP_OKAY=00, RESP_SLVERR=10.
- Sub-module axi_slave_ram: single-port 32-bit RAM with byte-enable write and registered read; shared by read and write paths since only one is active at a time.

Test Plan:
- Single-beat write then read: AW_ADDR=0x10, LEN=0, W_DATA=0xDEADBEEF, STRB=1111 → B_RESP=00. Read AR_ADDR=0x10, LEN=0 → R_DATA=0xDEADBEEF, R_LAST=1 on beat 1.
- 16-beat INCR burst: write words i·0x01010101 at AW_ADDR=0x100, LEN=15. Read the same address with LEN=15 while R_READY toggles every other cycle → 16 beats in order, R_LAST only on beat 16, data held while R_READY=0.
- Strobe: write 0xFFFFFFFF to 0x20, then write 0x00000000 with STRB=0101 → read returns 0xFF00FF00.
- Simultaneous AR_VALID and AW_VALID in IDLE → AR accepted first; AW accepted only after the read's R_LAST handshake.
- Early W_LAST: LEN=3 with W_LAST on beat 2 → all 4 beats written, B_RESP=10. B_READY held low 5 cycles → B_VALID stays 1.
- arst pulse mid-read at beat 3 of 8 → all outputs 0 in the same cycle; a new AR is accepted in IDLE after release. With AXI_SLAVE_RANGE_CHECK_EN and MEM_ADDR_WIDTH=10, a read at AR_ADDR=0x1000 → R_RESP=10, R_DATA=0.
